r_serial_sched: RTL

Round-robin scheduler that shares one `r_serial` measurement-noise estimator among NCH Kalman filter channels. It arbitrates between the channel requests and latches the winner's operands onto the estimator input bus. It pulses the estimator `start`, waits for `done` under a timeout watchdog, and returns R11/R22 to the granted channel with a per-channel valid pulse. It sits between the per-channel KF update engines and the single `r_serial` instance.

---
 rtl/r_serial_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/r_serial_sched.sv
// Round-robin scheduler sharing one r_serial estimator among NCH channels.
// Latches the winner's operands, runs start/done with a timeout watchdog.
module r_serial_sched #(
    parameter int N    = 20,
    parameter int FRAC = 10,
    parameter int NCH  = 4,
    parameter int TMO  = 15,
    localparam int CW  = $clog2(NCH),
    localparam int TW  = $clog2(TMO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*N-1:0] ch_beta,
    input  logic [NCH*N-1:0] ch_sigma2_00,
    input  logic [NCH*N-1:0] ch_sigma2_01,
    input  logic [NCH*N-1:0] ch_sigma2_10,
    input  logic [NCH*N-1:0] ch_sigma2_11,
    input  logic [NCH*N-1:0] ch_z00,
    input  logic [NCH*N-1:0] ch_z10,
    input  logic [NCH*N-1:0] ch_zhat00,
    input  logic [NCH*N-1:0] ch_zhat10,
    output logic             rs_start,
    output logic [N-1:0]     rs_beta,
    output logic [N-1:0]     rs_sigma2_00,
    output logic [N-1:0]     rs_sigma2_01,
    output logic [N-1:0]     rs_sigma2_10,
    output logic [N-1:0]     rs_sigma2_11,
    output logic [N-1:0]     rs_z00,
    output logic [N-1:0]     rs_z10,
    output logic [N-1:0]     rs_zhat00,
    output logic [N-1:0]     rs_zhat10,
    input  logic             rs_done,
    input  logic [N-1:0]     rs_R11,
    input  logic [N-1:0]     rs_R22,
    output logic [NCH-1:0]   res_valid,
    output logic [N-1:0]     res_R11,
    output logic [N-1:0]     res_R22,
    output logic             res_err,
    output logic             busy,
    output logic [CW-1:0]    gnt_ch
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] ptr;
    logic [TW-1:0] cnt;
    logic          found;
    logic [CW-1:0] win;
    int            idx;
    int            base;

    // First set request at or above ptr, wrapping at NCH
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
    end

    assign base = int'(win) * N;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            rs_start     <= 1'b0;
            rs_beta      <= '0;
            rs_sigma2_00 <= '0;
            rs_sigma2_01 <= '0;
            rs_sigma2_10 <= '0;
            rs_sigma2_11 <= '0;
            rs_z00       <= '0;
            rs_z10       <= '0;
            rs_zhat00    <= '0;
            rs_zhat10    <= '0;
            res_valid    <= '0;
            res_R11      <= '0;
            res_R22      <= '0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
            gnt_ch       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        rs_beta      <= ch_beta[base +: N];
                        rs_sigma2_00 <= ch_sigma2_00[base +: N];
                        rs_sigma2_01 <= ch_sigma2_01[base +: N];
                        rs_sigma2_10 <= ch_sigma2_10[base +: N];
                        rs_sigma2_11 <= ch_sigma2_11[base +: N];
                        rs_z00       <= ch_z00[base +: N];
                        rs_z10       <= ch_z10[base +: N];
                        rs_zhat00    <= ch_zhat00[base +: N];
                        rs_zhat10    <= ch_zhat10[base +: N];
                        gnt_ch       <= win;
                        busy         <= 1'b1;
                        rs_start     <= 1'b1;
                        ptr   <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rs_start <= 1'b0;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done takes priority over an expiring watchdog
                    if (rs_done) begin
                        res_R11   <= rs_R11;
                        res_R22   <= rs_R22;
                        res_err   <= 1'b0;
                        res_valid <= NCH'(1) << gnt_ch;
                        state     <= RESP;
                    end else if (cnt == TW'(TMO)) begin
                        res_R11   <= '0;
                        res_R22   <= '0;
                        res_err   <= 1'b1;
                        res_valid <= NCH'(1) << gnt_ch;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    res_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
